// File: rtl/io_buffer_pkg.sv
// Shared types and default geometry for the IO buffer unload path.
package io_buffer_pkg;
  localparam int ADDR_W_DEF    = 6;
  localparam int DATA_W_DEF    = 256;
  localparam int WORD_W_DEF    = 32;
  localparam int WORDS_PER_ROW = DATA_W_DEF / WORD_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_e;
endpackage

// File: rtl/io_row_serializer.sv
// Holds one buffer row and walks it out a word at a time, LS word first.
module io_row_serializer #(
  parameter int DATA_WIDTH = 256,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  last_word
);
  localparam int WORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [WORDS-1:0][WORD_WIDTH-1:0] row;
  logic [IDX_W-1:0]                 idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      idx <= '0;
    end else if (load) begin
      row <= rdata;
      idx <= '0;
    end else if (advance && !last_word) begin
      idx <= idx + 1'b1;
    end
  end

  assign word      = row[idx];
  assign last_word = (idx == IDX_W'(WORDS - 1));
endmodule

// File: rtl/io_buffer_unloader.sv
// Unloads a run of buffer rows onto a valid/ready word stream, one fetch per row.
module io_buffer_unloader
  import io_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int WORD_WIDTH = WORD_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   row_count,
  output logic                  busy,
  output logic                  done,
  output logic                  buf_read_enable,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  input  logic [DATA_WIDTH-1:0] buf_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic                  m_last
);
  state_e                state, state_n;
  logic [ADDR_WIDTH-1:0] row_addr;
  logic [ADDR_WIDTH:0]   rows_left;
  logic                  done_n;
  logic                  xfer, last_word, last_row;
  logic [WORD_WIDTH-1:0] word;

  assign xfer     = m_valid & m_ready;
  assign last_row = (rows_left == (ADDR_WIDTH+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      row_addr  <= '0;
      rows_left <= '0;
    end else begin
      state <= state_n;
      done  <= done_n;
      if (state == IDLE && start && row_count != '0) begin
        row_addr  <= start_addr;
        rows_left <= row_count;
      end else if (state == SEND && xfer && last_word && !last_row) begin
        // Address wraps naturally at 2^ADDR_WIDTH.
        row_addr  <= row_addr + 1'b1;
        rows_left <= rows_left - 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (row_count != '0) state_n = FETCH;
          else                 done_n  = 1'b1;
        end
      end
      FETCH: state_n = SEND;
      SEND: begin
        if (xfer && last_word) begin
          if (last_row) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  io_row_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == FETCH),
    .advance  (xfer),
    .rdata    (buf_rdata),
    .word     (word),
    .last_word(last_word)
  );

  assign busy            = (state != IDLE);
  assign buf_read_enable = (state == FETCH);
  assign buf_addr        = row_addr;
  assign m_valid         = (state == SEND);
  assign m_data          = word;
  assign m_last          = m_valid && last_word && last_row;
endmodule
